inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Dual-issue instruction buffer that sits directly upstream of the instruction dispatch unit.
- Accepts up to two decoded instructions per cycle from the fetch/decode path and stores them in program order in a circular FIFO.
- Presents the two oldest entries as inst_1 (older) and inst_2 (younger), with a valid per slot.
- Retires entries when dispatch pulses the matching fetch signal.

Parameters:
- DEPTH, 8, number of instruction entries; must be a power of two and >= 4.
- INS_PART_WID, 4, bit width of each instruction field (type, dest, src0, src1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- flush  input  1  discards all entries.
- wr1_valid  input  1  push instruction A (older of the pair).
- wr1_data  input  4*INS_PART_WID  {type, dest, src0, src1} of A.
- wr2_valid  input  1  push instruction B (younger of the pair).
- wr2_data  input  4*INS_PART_WID  {type, dest, src0, src1} of B.
- wr_ready  output  1  at least 2 free entries.
- inst_1_valid  output  1  head entry present.
- inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1  output  INS_PART_WID each  head entry fields.
- inst_1_fetch  input  1  dispatch consumed the head entry this cycle.
- inst_2_valid  output  1  second entry present.
- inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1  output  INS_PART_WID each  second entry fields.
- inst_2_fetch  input  1  dispatch consumed the second entry this cycle.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- State:
  - rd_ptr, wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - Storage array of DEPTH x 4*INS_PART_WID. Storage contents are not reset.
- Reset (rst_n low at a rising edge):
  - rd_ptr = wr_ptr = count = 0.
  - Consequently inst_1_valid = inst_2_valid = 0, wr_ready = 1, and all inst_* field outputs = 0.
  - Reset overrides flush, push and pop in the same cycle, including mid-stream.
- Read side (combinational from registered state, zero latency):
  - inst_1_valid = (count >= 1). inst_1_* = storage[rd_ptr] when valid, else 0.
  - inst_2_valid = (count >= 2). inst_2_* = storage[(rd_ptr+1) mod DEPTH] when valid, else 0.
- Pop rules (in-order retirement):
  - pop1 = inst_1_fetch & inst_1_valid.
  - pop2 = inst_2_fetch & inst_2_valid & pop1. inst_2_fetch without inst_1_fetch is ignored.
  - rd_ptr advances by pop1 + pop2.
- Push rules:
  - wr_ready = (DEPTH - count >= 2), evaluated on current-cycle registered count. Same-cycle pops do not raise it.
  - push1 = wr1_valid & wr_ready. push2 = wr2_valid & push1.
  - wr2_valid without wr1_valid is ignored.
  - When wr_ready = 0, pushes are dropped; the producer must hold data.
  - A is written at wr_ptr, B at wr_ptr+1 (mod DEPTH). wr_ptr advances by push1 + push2.
- Count update: count_next = count - (pop1+pop2) + (push1+push2).
  - Never exceeds DEPTH, never underflows.
- Pushed entries first appear on inst_* outputs the cycle after the push (1-cycle latency). No bypass from wr*_data to the outputs.
- Flush:
  - Sets rd_ptr = wr_ptr = count = 0 on the next edge.
  - Has priority over push and pop in the same cycle; both are discarded.
- Wrap-around: pointer arithmetic is modulo DEPTH. A two-wide push or pop that straddles index DEPTH-1 -> 0 must behave identically to the non-wrapping case.
- No state machine beyond pointers/count. All outputs are derived from registered state only, so there is no combinational path from any input to any output.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n = 0 for 2 cycles, then 1, no pushes.
  - Required: count = 0, inst_1_valid = inst_2_valid = 0, wr_ready = 1, all fields 0.
- Dual push/dual pop:
  - Stimulus: push A = {1,2,3,4}, B = {2,5,6,7}.
  - Required next cycle: inst_1 = {1,2,3,4} valid, inst_2 = {2,5,6,7} valid, count = 2.
  - Then assert inst_1_fetch and inst_2_fetch: count = 0 next cycle.
- Out-of-order fetch ignored:
  - Stimulus: 2 entries queued; assert inst_2_fetch only.
  - Required: count stays 2, outputs unchanged.
  - Then assert inst_1_fetch only: old inst_2 moves to inst_1, inst_2_valid = 0, count = 1.
- Full boundary:
  - Stimulus: push pairs until count = 6 (DEPTH = 8): wr_ready = 1. One more pair: count = 8, wr_ready = 0.
  - A further push with no pop is dropped: count stays 8.
  - A dual push with a dual pop at count = 8 is also dropped (wr_ready = 0): count = 6 next cycle.
- Wrap-around:
  - Stimulus: cycle 20 pairs with distinct tags through DEPTH = 8.
  - Required: the inst_1/inst_2 sequence exactly matches push order, including pairs straddling index 7 -> 0.
- Flush and reset mid-operation:
  - Flush with count = 5 plus simultaneous push and pop: count = 0 next cycle, inst_1_valid = 0.
  - rst_n = 0 with count = 4 plus a simultaneous push: count = 0 next cycle.

Source files
------------

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue in-order instruction buffer feeding dispatch
module inst_queue #(
    parameter int DEPTH        = 8,
    parameter int INS_PART_WID = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr1_valid,
    input  logic [4*INS_PART_WID-1:0] wr1_data,
    input  logic                      wr2_valid,
    input  logic [4*INS_PART_WID-1:0] wr2_data,
    output logic                      wr_ready,
    output logic                      inst_1_valid,
    output logic [INS_PART_WID-1:0]   inst_1_type,
    output logic [INS_PART_WID-1:0]   inst_1_dest,
    output logic [INS_PART_WID-1:0]   inst_1_src0,
    output logic [INS_PART_WID-1:0]   inst_1_src1,
    input  logic                      inst_1_fetch,
    output logic                      inst_2_valid,
    output logic [INS_PART_WID-1:0]   inst_2_type,
    output logic [INS_PART_WID-1:0]   inst_2_dest,
    output logic [INS_PART_WID-1:0]   inst_2_src0,
    output logic [INS_PART_WID-1:0]   inst_2_src1,
    input  logic                      inst_2_fetch,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 4 * INS_PART_WID;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop1;
    logic          w_pop2;
    logic          w_push1;
    logic          w_push2;
    logic [1:0]    w_pop_n;
    logic [1:0]    w_push_n;
    logic [PW-1:0] w_rd_ptr_p1;
    logic [PW-1:0] w_wr_ptr_p1;
    logic [DW-1:0] w_head;
    logic [DW-1:0] w_second;

    assign count        = r_count;
    assign inst_1_valid = (r_count != '0);
    assign inst_2_valid = (r_count >= CW'(2));
    // Readiness looks only at the registered count; a same-cycle pop never frees room early.
    assign wr_ready     = (r_count <= CW'(DEPTH - 2));

    assign w_pop1   = inst_1_fetch & inst_1_valid;
    assign w_pop2   = inst_2_fetch & inst_2_valid & w_pop1;
    assign w_push1  = wr1_valid & wr_ready;
    assign w_push2  = wr2_valid & w_push1;
    assign w_pop_n  = {1'b0, w_pop1} + {1'b0, w_pop2};
    assign w_push_n = {1'b0, w_push1} + {1'b0, w_push2};

    assign w_rd_ptr_p1 = r_rd_ptr + PW'(1);
    assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);

    assign w_head   = inst_1_valid ? r_mem[r_rd_ptr]    : '0;
    assign w_second = inst_2_valid ? r_mem[w_rd_ptr_p1] : '0;

    assign {inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1} = w_head;
    assign {inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1} = w_second;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
            r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            r_count  <= r_count - CW'(w_pop_n) + CW'(w_push_n);
        end
    end

    // Storage is deliberately left unreset; invalid slots are masked on the read side.
    always_ff @(posedge clk) begin
        if (w_push1 && !flush) begin
            r_mem[r_wr_ptr] <= wr1_data;
        end
        if (w_push2 && !flush) begin
            r_mem[w_wr_ptr_p1] <= wr2_data;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue
module tb_inst_queue;

    localparam int DEPTH = 8;
    localparam int W     = 4;

    logic        clk = 1'b0;
    logic        rst_n, flush, wr1_valid, wr2_valid, inst_1_fetch, inst_2_fetch;
    logic [15:0] wr1_data, wr2_data;
    logic        wr_ready, inst_1_valid, inst_2_valid;
    logic [W-1:0] inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1;
    logic [W-1:0] inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1;
    logic [3:0]  count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .INS_PART_WID(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr1_valid(wr1_valid), .wr1_data(wr1_data),
        .wr2_valid(wr2_valid), .wr2_data(wr2_data),
        .wr_ready(wr_ready),
        .inst_1_valid(inst_1_valid), .inst_1_type(inst_1_type), .inst_1_dest(inst_1_dest),
        .inst_1_src0(inst_1_src0), .inst_1_src1(inst_1_src1), .inst_1_fetch(inst_1_fetch),
        .inst_2_valid(inst_2_valid), .inst_2_type(inst_2_type), .inst_2_dest(inst_2_dest),
        .inst_2_src0(inst_2_src0), .inst_2_src1(inst_2_src1), .inst_2_fetch(inst_2_fetch),
        .count(count)
    );

    logic [15:0] d1_out, d2_out;
    assign d1_out = {inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1};
    assign d2_out = {inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1};

    typedef struct {
        logic        rst_n, flush, w1, w2, f1, f2;
        logic [15:0] a, b;
        int          e_cnt;
        logic        e_v1, e_v2, e_rdy;
        logic [15:0] e_d1, e_d2;
    } vec_t;

    function automatic vec_t mk(logic r, logic fl, logic w1, logic [15:0] a, logic w2,
                                logic [15:0] b, logic f1, logic f2, int cnt,
                                logic [15:0] d1, logic [15:0] d2);
        vec_t v;
        v.rst_n = r; v.flush = fl; v.w1 = w1; v.w2 = w2; v.f1 = f1; v.f2 = f2;
        v.a = a; v.b = b; v.e_cnt = cnt;
        v.e_v1 = (cnt >= 1); v.e_v2 = (cnt >= 2); v.e_rdy = (DEPTH - cnt >= 2);
        v.e_d1 = d1; v.e_d2 = d2;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic drive(logic r, logic fl, logic w1, logic [15:0] a, logic w2,
                         logic [15:0] b, logic f1, logic f2);
        rst_n = r; flush = fl; wr1_valid = w1; wr1_data = a; wr2_valid = w2; wr2_data = b;
        inst_1_fetch = f1; inst_2_fetch = f2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[24];
    logic [15:0] model_q[$];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(0,0, 0,16'h0000, 0,16'h0000, 0,0, 0, 16'h0000,16'h0000);
        tbl[1]  = mk(0,0, 0,16'h0000, 0,16'h0000, 0,0, 0, 16'h0000,16'h0000);
        tbl[2]  = mk(1,0, 0,16'h0000, 0,16'h0000, 0,0, 0, 16'h0000,16'h0000);
        tbl[3]  = mk(1,0, 1,16'h1234, 1,16'h2567, 0,0, 2, 16'h1234,16'h2567);
        tbl[4]  = mk(1,0, 0,16'h0000, 0,16'h0000, 1,1, 0, 16'h0000,16'h0000);
        tbl[5]  = mk(1,0, 1,16'h3111, 1,16'h3222, 0,0, 2, 16'h3111,16'h3222);
        tbl[6]  = mk(1,0, 0,16'h0000, 0,16'h0000, 0,1, 2, 16'h3111,16'h3222);
        tbl[7]  = mk(1,0, 0,16'h0000, 0,16'h0000, 1,0, 1, 16'h3222,16'h0000);
        tbl[8]  = mk(1,0, 0,16'h0000, 0,16'h0000, 1,0, 0, 16'h0000,16'h0000);
        tbl[9]  = mk(1,0, 0,16'h0000, 1,16'h4444, 0,0, 0, 16'h0000,16'h0000);
        tbl[10] = mk(1,0, 1,16'h5001, 1,16'h5002, 0,0, 2, 16'h5001,16'h5002);
        tbl[11] = mk(1,0, 1,16'h5003, 1,16'h5004, 0,0, 4, 16'h5001,16'h5002);
        tbl[12] = mk(1,0, 1,16'h5005, 1,16'h5006, 0,0, 6, 16'h5001,16'h5002);
        tbl[13] = mk(1,0, 1,16'h5007, 1,16'h5008, 0,0, 8, 16'h5001,16'h5002);
        tbl[14] = mk(1,0, 1,16'h6001, 1,16'h6002, 0,0, 8, 16'h5001,16'h5002);
        tbl[15] = mk(1,0, 1,16'h6003, 1,16'h6004, 1,1, 6, 16'h5003,16'h5004);
        tbl[16] = mk(1,0, 1,16'h7001, 1,16'h7002, 0,0, 8, 16'h5003,16'h5004);
        tbl[17] = mk(1,0, 0,16'h0000, 0,16'h0000, 1,0, 7, 16'h5004,16'h5005);
        tbl[18] = mk(1,0, 0,16'h0000, 0,16'h0000, 1,1, 5, 16'h5006,16'h5007);
        tbl[19] = mk(1,1, 1,16'h8001, 1,16'h8002, 1,1, 0, 16'h0000,16'h0000);
        tbl[20] = mk(1,0, 1,16'h9001, 1,16'h9002, 0,0, 2, 16'h9001,16'h9002);
        tbl[21] = mk(1,0, 1,16'h9003, 1,16'h9004, 0,0, 4, 16'h9001,16'h9002);
        tbl[22] = mk(0,0, 1,16'h9005, 1,16'h9006, 0,0, 0, 16'h0000,16'h0000);
        tbl[23] = mk(1,0, 0,16'h0000, 0,16'h0000, 0,0, 0, 16'h0000,16'h0000);

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst_n, tbl[i].flush, tbl[i].w1, tbl[i].a, tbl[i].w2, tbl[i].b,
                  tbl[i].f1, tbl[i].f2);
            tick();
            check($sformatf("vec%0d count", i), int'(count), tbl[i].e_cnt);
            check($sformatf("vec%0d inst_1_valid", i), int'(inst_1_valid), int'(tbl[i].e_v1));
            check($sformatf("vec%0d inst_2_valid", i), int'(inst_2_valid), int'(tbl[i].e_v2));
            check($sformatf("vec%0d wr_ready", i), int'(wr_ready), int'(tbl[i].e_rdy));
            check($sformatf("vec%0d inst_1", i), int'(d1_out), int'(tbl[i].e_d1));
            check($sformatf("vec%0d inst_2", i), int'(d2_out), int'(tbl[i].e_d2));
        end

        // Offset pointers by one so every later pair straddles an odd boundary, including 7 -> 0.
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 16'hBEEF, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 1, 0); tick();
        check("wrap offset count", int'(count), 0);
        drive(1, 0, 1, 16'hC000, 1, 16'hC001, 0, 0); tick();
        for (int k = 1; k <= 20; k++) begin
            check($sformatf("wrap%0d inst_1", k), int'(d1_out), 32'hC000 + 2 * (k - 1));
            check($sformatf("wrap%0d inst_2", k), int'(d2_out), 32'hC001 + 2 * (k - 1));
            check($sformatf("wrap%0d valid", k), int'({inst_1_valid, inst_2_valid}), 3);
            if (k < 20) drive(1, 0, 1, 16'(16'hC000 + 2 * k), 1, 16'(16'hC001 + 2 * k), 1, 1);
            else        drive(1, 0, 0, 0, 0, 0, 1, 1);
            tick();
        end
        check("wrap drained count", int'(count), 0);

        model_q.delete();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int c = 0; c < 600; c++) begin
            logic r, fl, w1, w2, f1, f2, rdy, p1, p2;
            logic [15:0] a, b, e1, e2;
            r  = ($urandom_range(99) >= 2);
            fl = ($urandom_range(99) < 3);
            w1 = ($urandom_range(99) < 70);
            w2 = ($urandom_range(99) < 60);
            f1 = ($urandom_range(99) < 55);
            f2 = ($urandom_range(99) < 55);
            a  = 16'($urandom);
            b  = 16'($urandom);
            drive(r, fl, w1, a, w2, b, f1, f2);
            rdy = (DEPTH - model_q.size() >= 2);
            p1  = f1 && (model_q.size() >= 1);
            p2  = p1 && f2 && (model_q.size() >= 2);
            if (!r || fl) begin
                model_q.delete();
            end else begin
                if (p1) void'(model_q.pop_front());
                if (p2) void'(model_q.pop_front());
                if (w1 && rdy) begin
                    model_q.push_back(a);
                    if (w2) model_q.push_back(b);
                end
            end
            tick();
            e1 = (model_q.size() >= 1) ? model_q[0] : 16'h0;
            e2 = (model_q.size() >= 2) ? model_q[1] : 16'h0;
            check($sformatf("rnd%0d count", c), int'(count), model_q.size());
            check($sformatf("rnd%0d wr_ready", c), int'(wr_ready),
                  int'(DEPTH - model_q.size() >= 2));
            check($sformatf("rnd%0d valids", c), int'({inst_1_valid, inst_2_valid}),
                  int'({model_q.size() >= 1, model_q.size() >= 2}));
            check($sformatf("rnd%0d inst_1", c), int'(d1_out), int'(e1));
            check($sformatf("rnd%0d inst_2", c), int'(d2_out), int'(e2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
